// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Upstream driver for an 8:1 select mux. It takes one 8-bit word over a
// valid/ready handshake and holds it on the mux data bus i. It then steps the
// 3-bit select s through all eight positions, so the mux serialises the word.
// The bit_valid, first and last strobes frame each serial bit for the consumer.
//
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready
// are both high. in_ready is combinational and never depends on in_valid. It
// is high when idle, on the final beat of a word, and whenever abort is high.
// While in_ready is low, the source holds in_valid and in_data stable.
module mux_scan_sequencer #(
    parameter int DWELL     = 1,     // cycles each select value is held (>=1)
    parameter bit MSB_FIRST = 1'b0   // 0: sel 0->7, 1: sel 7->0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [2:0] s,
    output logic [7:0] i,
    output logic       bit_valid,
    output logic       first,
    output logic       last
);

    localparam int CW_RAW = $clog2(DWELL + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [2:0]    START_SEL  = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0]    END_SEL    = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] dwell_cnt;
    logic          beat_end;
    logic          word_end;
    logic          accept;
    logic [2:0]    next_sel;

    // Beat and word boundaries, handshake, and the next select position.
    assign beat_end = (dwell_cnt == DWELL_LAST);
    assign word_end = (state == SCAN) & beat_end & last;
    assign in_ready = (state == IDLE) | word_end | abort;
    assign accept   = in_valid & in_ready;
    assign next_sel = MSB_FIRST ? (s - 3'd1) : (s + 3'd1);

    // Scan FSM. A new word loads first, then abort or end of word returns to
    // idle, and otherwise the select advances one position per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= START_SEL;
            i         <= 8'h00;
            dwell_cnt <= '0;
            bit_valid <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
        end else if (accept) begin
            // Also covers back-to-back and abort-with-new-word: no bubble.
            state     <= SCAN;
            s         <= START_SEL;
            i         <= in_data;
            dwell_cnt <= '0;
            bit_valid <= 1'b1;
            first     <= 1'b1;
            last      <= 1'b0;
        end else if (abort || word_end) begin
            // i keeps the last word so the mux input stays quiet.
            state     <= IDLE;
            s         <= START_SEL;
            dwell_cnt <= '0;
            bit_valid <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
        end else if (state == SCAN) begin
            if (!beat_end) begin
                dwell_cnt <= dwell_cnt + CW'(1);
            end else begin
                // Not the last beat here, so s cannot wrap within a word.
                dwell_cnt <= '0;
                s         <= next_sel;
                first     <= 1'b0;
                last      <= (next_sel == END_SEL);
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer. Instance a uses DWELL=1 with LSB
// first, and instance b uses DWELL=3 with MSB first. y is the 8:1 mux output
// that each instance drives.
module tb_mux_scan_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT a: DWELL=1, LSB first ----------------
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_abort;
    logic [2:0] a_s;
    logic [7:0] a_i;
    logic       a_bv, a_first, a_last;
    logic       a_y;

    mux_scan_sequencer #(.DWELL(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .abort(a_abort), .s(a_s), .i(a_i),
        .bit_valid(a_bv), .first(a_first), .last(a_last)
    );
    assign a_y = a_i[a_s];

    // ---------------- DUT b: DWELL=3, MSB first ----------------
    logic [7:0] b_data;
    logic       b_valid, b_ready, b_abort;
    logic [2:0] b_s;
    logic [7:0] b_i;
    logic       b_bv, b_first, b_last;
    logic       b_y;

    mux_scan_sequencer #(.DWELL(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .abort(b_abort), .s(b_s), .i(b_i),
        .bit_valid(b_bv), .first(b_first), .last(b_last)
    );
    assign b_y = b_i[b_s];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [0:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ab;
        logic       rdy;
        logic [2:0] s;
        logic       bv;
        logic       f;
        logic       l;
        logic [7:0] i;
        logic       y;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic ab,
                                input logic rdy, input logic [2:0] s, input logic bv,
                                input logic f, input logic l, input logic [7:0] i,
                                input logic y);
        vec_t t;
        t.v = v; t.d = d; t.ab = ab; t.rdy = rdy; t.s = s;
        t.bv = bv; t.f = f; t.l = l; t.i = i; t.y = y;
        vecs.push_back(t);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_table();
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            a_valid = vecs[k].v;
            a_data  = vecs[k].d;
            a_abort = vecs[k].ab;
            #1;
            chk($sformatf("v%0d ready", k), 32'(a_ready), 32'(vecs[k].rdy));
            chk($sformatf("v%0d s", k),     32'(a_s),     32'(vecs[k].s));
            chk($sformatf("v%0d bv", k),    32'(a_bv),    32'(vecs[k].bv));
            chk($sformatf("v%0d first", k), 32'(a_first), 32'(vecs[k].f));
            chk($sformatf("v%0d last", k),  32'(a_last),  32'(vecs[k].l));
            chk($sformatf("v%0d i", k),     32'(a_i),     32'(vecs[k].i));
            chk($sformatf("v%0d y", k),     32'(a_y),     32'(vecs[k].y));
        end
        @(negedge clk);
        a_valid = 1'b0; a_data = 8'h00; a_abort = 1'b0;
    endtask

    // Back-to-back words with in_valid held: 16 contiguous serial bits.
    task automatic run_b2b();
        int   n_acc;
        int   bv_cnt;
        logic acc;
        logic [0:0] e;
        n_acc  = 0;
        bv_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'hA5;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (a_bv) begin
                if (exp_q.size() == 0) begin
                    chk("b2b queue underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("b2b y bit%0d", bv_cnt), 32'(a_y), 32'(e));
                end
                chk($sformatf("b2b ready bit%0d", bv_cnt), 32'(a_ready), 32'(a_s == 3'd7));
                bv_cnt++;
            end else if (bv_cnt > 0 && bv_cnt < 16) begin
                chk("b2b bubble", 32'(bv_cnt), 32'd16);
            end
            acc = a_valid & a_ready;
            if (acc) begin
                for (int b = 0; b < 8; b++) exp_q.push_back(a_data[b]);
                n_acc++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (n_acc == 1) a_data = 8'h3C;
                else a_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b accepts", 32'(n_acc), 32'd2);
        chk("b2b bit count", 32'(bv_cnt), 32'd16);
        chk("b2b queue empty", 32'(exp_q.size()), 32'd0);
        a_valid = 1'b0;
        a_data  = 8'h00;
    endtask

    // DWELL=3, MSB first, word 8'h80.
    task automatic run_dwell();
        logic [2:0] es;
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 8'h80;
        #1;
        chk("dw idle ready", 32'(b_ready), 32'd1);
        chk("dw idle s", 32'(b_s), 32'd7);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            b_valid = 1'b0;
            b_data  = 8'h00;
            #1;
            es = 3'(7 - k / 3);
            chk($sformatf("dw%0d s", k),     32'(b_s),     32'(es));
            chk($sformatf("dw%0d bv", k),    32'(b_bv),    32'd1);
            chk($sformatf("dw%0d first", k), 32'(b_first), 32'(k < 3));
            chk($sformatf("dw%0d last", k),  32'(b_last),  32'(k >= 21));
            chk($sformatf("dw%0d y", k),     32'(b_y),     32'(k < 3));
            chk($sformatf("dw%0d ready", k), 32'(b_ready), 32'(k == 23));
        end
        @(negedge clk);
        #1;
        chk("dw end bv", 32'(b_bv), 32'd0);
        chk("dw end s", 32'(b_s), 32'd7);
        chk("dw end i", 32'(b_i), 32'h80);
    endtask

    // Asynchronous reset in the middle of a scan.
    task automatic run_async_reset();
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = 8'hC3;
        @(negedge clk);
        a_valid = 1'b0;
        a_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("ar pre s", 32'(a_s), 32'd3);
        chk("ar pre bv", 32'(a_bv), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar s", 32'(a_s), 32'd0);
        chk("ar i", 32'(a_i), 32'd0);
        chk("ar bv", 32'(a_bv), 32'd0);
        chk("ar first", 32'(a_first), 32'd0);
        chk("ar last", 32'(a_last), 32'd0);
        chk("ar b s", 32'(b_s), 32'd7);
        chk("ar b i", 32'(b_i), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ar ready a", 32'(a_ready), 32'd1);
        chk("ar ready b", 32'(b_ready), 32'd1);
        chk("ar post bv", 32'(a_bv), 32'd0);
    endtask

    // ---------------- main ----------------
    initial begin
        a_valid = 1'b0; a_data = 8'h00; a_abort = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_abort = 1'b0;

        // Basic scan of 8'hA5: y = 1,0,1,0,0,1,0,1 on s = 0..7.
        add(1, 8'hA5, 0,  1, 3'd0, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0,  0, 3'd0, 1, 1, 0, 8'hA5, 1);
        add(0, 8'h00, 0,  0, 3'd1, 1, 0, 0, 8'hA5, 0);
        add(0, 8'h00, 0,  0, 3'd2, 1, 0, 0, 8'hA5, 1);
        add(0, 8'h00, 0,  0, 3'd3, 1, 0, 0, 8'hA5, 0);
        add(0, 8'h00, 0,  0, 3'd4, 1, 0, 0, 8'hA5, 0);
        add(0, 8'h00, 0,  0, 3'd5, 1, 0, 0, 8'hA5, 1);
        add(0, 8'h00, 0,  0, 3'd6, 1, 0, 0, 8'hA5, 0);
        add(0, 8'h00, 0,  1, 3'd7, 1, 0, 1, 8'hA5, 1);
        add(0, 8'h00, 0,  1, 3'd0, 0, 0, 0, 8'hA5, 1);
        // 8'h3C with a stray in_valid (8'hFF) at s=2: it is ignored.
        add(1, 8'h3C, 0,  1, 3'd0, 0, 0, 0, 8'hA5, 1);
        add(0, 8'h00, 0,  0, 3'd0, 1, 1, 0, 8'h3C, 0);
        add(0, 8'h00, 0,  0, 3'd1, 1, 0, 0, 8'h3C, 0);
        add(1, 8'hFF, 0,  0, 3'd2, 1, 0, 0, 8'h3C, 1);
        add(0, 8'h00, 0,  0, 3'd3, 1, 0, 0, 8'h3C, 1);
        add(0, 8'h00, 0,  0, 3'd4, 1, 0, 0, 8'h3C, 1);
        add(0, 8'h00, 0,  0, 3'd5, 1, 0, 0, 8'h3C, 1);
        add(0, 8'h00, 0,  0, 3'd6, 1, 0, 0, 8'h3C, 0);
        add(0, 8'h00, 0,  1, 3'd7, 1, 0, 1, 8'h3C, 0);
        add(0, 8'h00, 0,  1, 3'd0, 0, 0, 0, 8'h3C, 0);
        // 8'h5A aborted at s=4 with no new word.
        add(1, 8'h5A, 0,  1, 3'd0, 0, 0, 0, 8'h3C, 0);
        add(0, 8'h00, 0,  0, 3'd0, 1, 1, 0, 8'h5A, 0);
        add(0, 8'h00, 0,  0, 3'd1, 1, 0, 0, 8'h5A, 1);
        add(0, 8'h00, 0,  0, 3'd2, 1, 0, 0, 8'h5A, 0);
        add(0, 8'h00, 0,  0, 3'd3, 1, 0, 0, 8'h5A, 1);
        add(0, 8'h00, 1,  1, 3'd4, 1, 0, 0, 8'h5A, 1);
        add(0, 8'h00, 0,  1, 3'd0, 0, 0, 0, 8'h5A, 0);
        // 8'h96 aborted at s=3 while 8'hFF is offered: it restarts at s=0.
        add(1, 8'h96, 0,  1, 3'd0, 0, 0, 0, 8'h5A, 0);
        add(0, 8'h00, 0,  0, 3'd0, 1, 1, 0, 8'h96, 0);
        add(0, 8'h00, 0,  0, 3'd1, 1, 0, 0, 8'h96, 1);
        add(0, 8'h00, 0,  0, 3'd2, 1, 0, 0, 8'h96, 1);
        add(1, 8'hFF, 1,  1, 3'd3, 1, 0, 0, 8'h96, 0);
        add(0, 8'h00, 0,  0, 3'd0, 1, 1, 0, 8'hFF, 1);
        add(0, 8'h00, 0,  0, 3'd1, 1, 0, 0, 8'hFF, 1);
        add(0, 8'h00, 0,  0, 3'd2, 1, 0, 0, 8'hFF, 1);
        add(0, 8'h00, 0,  0, 3'd3, 1, 0, 0, 8'hFF, 1);
        add(0, 8'h00, 0,  0, 3'd4, 1, 0, 0, 8'hFF, 1);
        add(0, 8'h00, 0,  0, 3'd5, 1, 0, 0, 8'hFF, 1);
        add(0, 8'h00, 0,  0, 3'd6, 1, 0, 0, 8'hFF, 1);
        add(0, 8'h00, 0,  1, 3'd7, 1, 0, 1, 8'hFF, 1);
        add(0, 8'h00, 0,  1, 3'd0, 0, 0, 0, 8'hFF, 1);

        // Reset state.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst a s", 32'(a_s), 32'd0);
        chk("rst a i", 32'(a_i), 32'd0);
        chk("rst a bv", 32'(a_bv), 32'd0);
        chk("rst a first", 32'(a_first), 32'd0);
        chk("rst a last", 32'(a_last), 32'd0);
        chk("rst a ready", 32'(a_ready), 32'd1);
        chk("rst b s", 32'(b_s), 32'd7);
        chk("rst b ready", 32'(b_ready), 32'd1);

        run_table();
        run_b2b();
        run_dwell();
        run_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
